// File: rtl/axi_pkg.sv
// Shared AXI4 types and constants for the slave memory and its address generators.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Wrapping bursts only make sense for power-of-two beat counts of 2..16.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI4 beat-address sequencer: next address after the current beat
// plus a per-transaction legality flag.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              legal_o
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] bytes_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic [ADDR_W-1:0] incr_s;

  // Next beat address for each burst type
  always_comb begin
    bytes_s     = ONE << size_i;
    // (len+1)*bytes is a power of two whenever the wrap length is legal
    wrap_mask_s = (({{(ADDR_W-8){1'b0}}, len_i} + ONE) << size_i) - ONE;
    incr_s      = (addr_i & ~(bytes_s - ONE)) + bytes_s;
    case (burst_i)
      INCR:    next_addr_o = incr_s;
      WRAP:    next_addr_o = (addr_i & ~wrap_mask_s) | ((addr_i + bytes_s) & wrap_mask_s);
      default: next_addr_o = addr_i;
    endcase
  end

  // Transaction-level legality of size, burst type and wrap length
  always_comb begin
    legal_o = (int'(size_i) <= MAX_SIZE) && (burst_i != 2'b11) &&
              ((burst_i != WRAP) || wrap_len_ok(len_i));
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent single-outstanding write and read engines
// sharing one word-addressed array with byte-lane writes.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * STRB_W);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [7:0]        aw_len_q, w_cnt_q;
  logic [2:0]        aw_size_q;
  logic [1:0]        aw_burst_q;
  logic              w_err_q;
  logic              aw_fire_s, w_fire_s, b_fire_s, w_last_beat_s, w_beat_err_s, w_legal_s;
  logic [ADDR_W-1:0] w_next_addr_s;
  logic [IDX_W-1:0]  w_idx_s;

  assign aw_fire_s     = AWVALID && awready_q;
  assign w_fire_s      = WVALID && wready_q;
  assign b_fire_s      = BREADY && bvalid_q;
  assign w_last_beat_s = (w_cnt_q == aw_len_q);
  assign w_beat_err_s  = !w_legal_s || (aw_addr_q >= MEM_BYTES);
  assign w_idx_s       = aw_addr_q[OFF +: IDX_W];

  axi_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_addr_gen (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .size_i      (aw_size_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (w_next_addr_s),
    .legal_o     (w_legal_s)
  );

  // Write FSM state and its registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Write FSM next state; the burst ends on beat count, never on WLAST
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (aw_fire_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
      W_DATA: if (w_fire_s && w_last_beat_s) w_state_d = W_RESP; else w_state_d = W_DATA;
      W_RESP: if (b_fire_s) w_state_d = W_IDLE; else w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs, decoded from the next state so they register cleanly
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write transaction fields, beat counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_id_q    <= {ID_W{1'b0}};
      aw_addr_q  <= {ADDR_W{1'b0}};
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      w_cnt_q    <= 8'd0;
      w_err_q    <= 1'b0;
    end else if (aw_fire_s) begin
      aw_id_q    <= AWID;
      aw_addr_q  <= AWADDR;
      aw_len_q   <= AWLEN;
      aw_size_q  <= AWSIZE;
      aw_burst_q <= AWBURST;
      w_cnt_q    <= 8'd0;
      w_err_q    <= 1'b0;
    end else if (w_fire_s) begin
      aw_addr_q <= w_next_addr_s;
      w_cnt_q   <= w_cnt_q + 8'd1;
      if (w_beat_err_s || (WLAST != w_last_beat_s)) begin
        w_err_q <= 1'b1;
      end
    end
  end

  // Byte-lane memory write; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_fire_s && !w_beat_err_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) begin
          mem_q[w_idx_s][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = aw_id_q;
  assign BRESP   = {w_err_q, 1'b0};

  // ---------------- read path ----------------
  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q, r_cnt_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic              ar_fire_s, r_fire_s, r_last_beat_s, r_load_s, r_beat_err_s, r_legal_s;
  logic [ADDR_W-1:0] r_ag_addr_s, r_next_addr_s, r_beat_addr_s;
  logic [7:0]        r_ag_len_s;
  logic [2:0]        r_ag_size_s;
  logic [1:0]        r_ag_burst_s;
  logic [IDX_W-1:0]  r_idx_s;

  assign ar_fire_s     = ARVALID && arready_q;
  assign r_fire_s      = RREADY && rvalid_q;
  assign r_last_beat_s = (r_cnt_q == ar_len_q);
  assign r_load_s      = ar_fire_s || (r_fire_s && !r_last_beat_s);

  // While idle the generator checks the incoming request so beat 0 can be fetched at once
  always_comb begin
    if (r_state_q == R_IDLE) begin
      r_ag_addr_s  = ARADDR;
      r_ag_len_s   = ARLEN;
      r_ag_size_s  = ARSIZE;
      r_ag_burst_s = ARBURST;
    end else begin
      r_ag_addr_s  = ar_addr_q;
      r_ag_len_s   = ar_len_q;
      r_ag_size_s  = ar_size_q;
      r_ag_burst_s = ar_burst_q;
    end
  end

  axi_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_addr_gen (
    .addr_i      (r_ag_addr_s),
    .len_i       (r_ag_len_s),
    .size_i      (r_ag_size_s),
    .burst_i     (r_ag_burst_s),
    .next_addr_o (r_next_addr_s),
    .legal_o     (r_legal_s)
  );

  assign r_beat_addr_s = ar_fire_s ? ARADDR : r_next_addr_s;
  assign r_beat_err_s  = !r_legal_s || (r_beat_addr_s >= MEM_BYTES);
  assign r_idx_s       = r_beat_addr_s[OFF +: IDX_W];

  // Read FSM state and its registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_fire_s) r_state_d = R_DATA; else r_state_d = R_IDLE;
      R_DATA: if (r_fire_s && r_last_beat_s) r_state_d = R_IDLE; else r_state_d = R_DATA;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read transaction fields and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rid_q      <= {ID_W{1'b0}};
      ar_addr_q  <= {ADDR_W{1'b0}};
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      r_cnt_q    <= 8'd0;
    end else if (ar_fire_s) begin
      rid_q      <= ARID;
      ar_addr_q  <= ARADDR;
      ar_len_q   <= ARLEN;
      ar_size_q  <= ARSIZE;
      ar_burst_q <= ARBURST;
      r_cnt_q    <= 8'd0;
    end else if (r_fire_s && !r_last_beat_s) begin
      ar_addr_q <= r_next_addr_s;
      r_cnt_q   <= r_cnt_q + 8'd1;
    end
  end

  // Beat payload is loaded only on advance, so it holds while the master stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DATA_W{1'b0}};
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else if (r_load_s) begin
      rdata_q <= r_beat_err_s ? {DATA_W{1'b0}} : mem_q[r_idx_s];
      rresp_q <= r_beat_err_s ? RESP_SLVERR : RESP_OKAY;
      rlast_q <= ar_fire_s ? (ARLEN == 8'd0) : ((r_cnt_q + 8'd1) == ar_len_q);
    end else if (r_fire_s) begin
      rlast_q <= 1'b0;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
Parametrised AXI4 slave memory, written as synthesizable RTL. It is the successor to the fixed-width AXI bus definition.
- Widths are generalised; AXI4 8-bit burst lengths are used; WID is removed.
- Adds FIXED, INCR and WRAP burst address generation, byte strobes and error responses.
- Sits behind the slave side of the AXI interface as the default DUT/responder for master-VIP tests.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width; power of two, 8..128
MEM_DEPTH, 1024, memory size in DATA_W words; addresses at or above MEM_DEPTH*DATA_W/8 are out of range

Ports:
clk  in  1  clock (all logic on rising edge)
rst_n  in  1  asynchronous active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address channel
AWVALID in 1; AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data channel
WVALID in 1; WREADY out 1  write data handshake
BID/BRESP  out  ID_W/2  write response
BVALID out 1; BREADY in 1  write response handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address channel
ARVALID in 1; ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data channel
RVALID out 1; RREADY in 1  read data handshake

Behaviour:
- Reset: every output is driven 0 (READYs, VALIDs, RLAST, IDs, data, resps). FSMs go to IDLE. Memory contents are not reset.
- Reset asserted mid-burst: the burst is abandoned immediately and no response is issued.
- A handshake occurs when VALID && READY are both high at a rising edge.
- Write and read paths are independent, each with one outstanding transaction.
- Write FSM states and transitions:
  - W_IDLE: AWREADY=1. On AW handshake, latch id/addr/len/size/burst, clear beat count and error flag, go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write every byte lane whose WSTRB bit is set, unless the beat is in error. Then advance the address and increment the beat count. When the beat count equals len, go to W_RESP.
  - W_RESP: BVALID=1, BID=latched id, BRESP per the error flag. On B handshake, go to W_IDLE.
- WLAST checking: the burst ends on beat count, not on WLAST. WLAST high before the final beat, or low on the final beat, sets the error flag (SLVERR).
- Read FSM states and transitions:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and go to R_DATA.
  - R_DATA: RVALID=1 with RDATA/RRESP for the current beat; RLAST=1 on beat len. RDATA/RRESP/RLAST/RID stay stable while RVALID && !RREADY.
  - On R handshake: advance the address. After beat len, return to R_IDLE.
- Latency: first RVALID in the cycle after AR handshake; BVALID in the cycle after the last W handshake.
- Address generation, with bytes = 1<<size:
  - FIXED: address constant.
  - INCR: addr + bytes, after the first beat aligned down to bytes.
  - WRAP: boundary = (len+1)*bytes; next = base | ((addr+bytes) mod boundary), where base = addr aligned down to boundary.
- Error responses (SLVERR = 2'b10), per transaction:
  - size > log2(DATA_W/8);
  - WRAP with len not in {1,3,7,15};
  - burst = 2'b11 (reserved).
- Out-of-range beats: writes to such beats are dropped and flagged SLVERR. Reads of such beats return RDATA=0, RRESP=SLVERR for that beat only.
- Good responses are OKAY (00). EXOKAY and DECERR are never generated.
- Narrow transfers: byte lanes are taken from WSTRB as driven; the full word is returned on reads.
- Same-cycle read and write to the same word: the read returns the pre-write data.

Decomposition:
- Package axi_pkg:
  - burst_e {FIXED=0, INCR=1, WRAP=2};
  - RESP_OKAY and RESP_SLVERR constants;
  - write-state and read-state enums.
- Sub-module axi_addr_gen: combinational next-address and legality check, from addr/len/size/burst. Instanced once for the write path and once for the read path.

Test Plan:
- Reset: rst_n low mid-read at beat 2 of 4 -> RVALID=0 immediately. After release, ARREADY=1 and AWREADY=1 one cycle later.
- INCR write then read:
  - stimulus: AW addr 0x100, len 3, size 2; data 0xA0..0xA3; all WSTRB=4'hF;
  - -> BRESP=00, BID=AWID;
  - -> read returns 0xA0,0xA1,0xA2,0xA3 with RLAST on the 4th beat only.
- WRAP read:
  - stimulus: ARADDR 0x38, len 3, size 2, WRAP;
  - -> addresses 0x38,0x3C,0x30,0x34;
  - -> RRESP=00 on all beats.
- Strobe and backpressure:
  - stimulus: write 0xDEADBEEF with WSTRB 4'b0101 over 0x00000000; read with RREADY low for 3 cycles;
  - -> read returns 0x00AD00EF;
  - -> RDATA held stable while RREADY is low.
- Errors:
  - AWSIZE=3 with DATA_W=32 -> BRESP=10 and memory unchanged;
  - WLAST early on beat 1 of a len=3 burst -> BRESP=10 after 4 beats;
  - read at 0x1000 (out of range) -> RDATA=0, RRESP=10.
- Concurrency: AW and AR handshakes in the same cycle on the same address 0x40 -> read returns the old data and the write still completes with OKAY.
